// File: rtl/spreading_factors_pkg.sv
// Spreading-factor encoding shared by the DCSK modulator and its neighbours.
// Chips per half-frame is 4 << sf.
package spreading_factors_pkg;

  typedef enum logic [1:0] {
    SF4  = 2'd0,
    SF8  = 2'd1,
    SF16 = 2'd2,
    SF32 = 2'd3
  } sf_t;

endpackage

// File: rtl/dcsk_frame_mod_if.sv
// Handshake bundle for dcsk_frame_mod: message bit intake, chaos intake, chip output.
// The slave modport is the modulator's view; the master modport is its environment's.
interface dcsk_frame_mod_if
  import spreading_factors_pkg::*;
#(
  parameter int unsigned CHIP_W = 8
) ();

  sf_t                      sf;
  logic                     bit_valid;
  logic                     bit_data;
  logic                     bit_ready;
  logic                     chaos_valid;
  logic signed [CHIP_W-1:0] chaos_data;
  logic                     chaos_ready;
  logic                     out_valid;
  logic signed [CHIP_W-1:0] out_data;
  logic                     out_ref;
  logic                     out_last;
  logic                     out_ready;

  modport master (
    output sf, bit_valid, bit_data, chaos_valid, chaos_data, out_ready,
    input  bit_ready, chaos_ready, out_valid, out_data, out_ref, out_last
  );

  modport slave (
    input  sf, bit_valid, bit_data, chaos_valid, chaos_data, out_ready,
    output bit_ready, chaos_ready, out_valid, out_data, out_ref, out_last
  );

endinterface

// File: rtl/dcsk_frame_mod.sv
// DCSK frame modulator: per message bit, N reference chips taken from the chaos source,
// then the same N samples replayed (saturating-negated for bit 0) as information chips.
module dcsk_frame_mod
  import spreading_factors_pkg::*;
#(
  parameter int unsigned CHIP_W = 8,
  parameter int unsigned MAX_N  = 32
) (
  input logic             clk,
  input logic             rst,
  dcsk_frame_mod_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_N);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRef  = 2'd1;
  localparam logic [1:0] StInfo = 2'd2;

  localparam logic signed [CHIP_W-1:0] ChipMin = {1'b1, {(CHIP_W-1){1'b0}}};
  localparam logic signed [CHIP_W-1:0] ChipMax = {1'b0, {(CHIP_W-1){1'b1}}};

  logic [1:0]               state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [CntW-1:0]          last_idx_q, last_idx_d;
  logic                     bit_q, bit_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [CHIP_W-1:0] out_data_q, out_data_d;
  logic                     out_ref_q, out_ref_d;
  logic                     out_last_q, out_last_d;
  logic signed [CHIP_W-1:0] ref_buf_q [MAX_N];

  logic                     out_free;
  logic                     chaos_fire;
  logic                     info_load;
  logic                     cnt_at_last;
  logic [CntW-1:0]          sf_last_idx;
  logic signed [CHIP_W-1:0] replay;
  logic signed [CHIP_W-1:0] info_chip;

  // Negating the most negative code would wrap, so it clamps to the most positive one.
  function automatic logic signed [CHIP_W-1:0] sat_neg(input logic signed [CHIP_W-1:0] x);
    return (x == ChipMin) ? ChipMax : -x;
  endfunction

  always_comb begin
    sf_last_idx = CntW'(3);
    unique case (bus.sf[1:0])
      2'd0: sf_last_idx = CntW'(3);
      2'd1: sf_last_idx = CntW'(7);
      2'd2: sf_last_idx = CntW'(15);
      2'd3: sf_last_idx = CntW'(31);
    endcase
  end

  // The output register can take a new chip whenever it is empty or draining this cycle.
  assign out_free    = !out_valid_q || bus.out_ready;
  assign cnt_at_last = (cnt_q == last_idx_q);
  assign chaos_fire  = (state_q == StRef) && out_free && bus.chaos_valid;
  assign info_load   = (state_q == StInfo) && out_free;
  assign replay      = ref_buf_q[cnt_q];
  assign info_chip   = bit_q ? replay : sat_neg(replay);

  assign bus.bit_ready   = (state_q == StIdle);
  assign bus.chaos_ready = (state_q == StRef) && out_free;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_ref     = out_ref_q;
  assign bus.out_last    = out_last_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    bit_d      = bit_q;
    case (state_q)
      StIdle: begin
        if (bus.bit_valid) begin
          bit_d      = bus.bit_data;
          last_idx_d = sf_last_idx;
          cnt_d      = '0;
          state_d    = StRef;
        end
      end
      StRef: begin
        if (chaos_fire) begin
          if (cnt_at_last) begin
            cnt_d   = '0;
            state_d = StInfo;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StInfo: begin
        if (info_load) begin
          if (cnt_at_last) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ref_d   = out_ref_q;
    out_last_d  = out_last_q;
    if (chaos_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.chaos_data;
      out_ref_d   = 1'b1;
      out_last_d  = 1'b0;
    end else if (info_load) begin
      out_valid_d = 1'b1;
      out_data_d  = info_chip;
      out_ref_d   = 1'b0;
      out_last_d  = cnt_at_last;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_idx_q  <= '0;
      bit_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ref_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_idx_q  <= last_idx_d;
      bit_q       <= bit_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ref_q   <= out_ref_d;
      out_last_q  <= out_last_d;
    end
  end

  // Reference samples need no reset: every entry is written before it is replayed.
  always_ff @(posedge clk) begin
    if (chaos_fire) begin
      ref_buf_q[cnt_q] <= bus.chaos_data;
    end
  end

endmodule
